// File: rtl/modem_cfg_ctrl_if.sv
// rtl/modem_cfg_ctrl_if.sv - host register-write, commit and sweep strobes for modem_cfg_ctrl
interface modem_cfg_ctrl_if;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [31:0] wr_data;
  logic        commit;
  logic        sweep_start;

  modport master (
    output wr_en,
    output wr_addr,
    output wr_data,
    output commit,
    output sweep_start
  );

  modport slave (
    input wr_en,
    input wr_addr,
    input wr_data,
    input commit,
    input sweep_start
  );
endinterface

// File: rtl/modem_cfg_ctrl.sv
// rtl/modem_cfg_ctrl.sv - shadow/active config bank, datapath reset/settle sequencer and carrier sweep
module modem_cfg_ctrl #(
  parameter int          PHASE_WIDTH  = 32,
  parameter int          MOVE_WIDTH   = 20,
  parameter int          DEEP_WIDTH   = 12,
  parameter int          FACTOR_WIDTH = 16,
  parameter int unsigned DEF_CENTER   = 32'd459561501,
  parameter int unsigned DEF_MOVE     = 32'd262,
  parameter int unsigned DEF_DEEP     = 32'd4090,
  parameter int unsigned DEF_FACTOR   = 32'd400,
  parameter int          RST_CYC      = 4,
  parameter int          SETTLE_CYC   = 1024,
  parameter int          DWELL_CYC    = 65536
) (
  input  logic                    clk_in,
  input  logic                    sys_rst_n,
  modem_cfg_ctrl_if.slave         host,
  output logic [PHASE_WIDTH-1:0]  center_fre,
  output logic [MOVE_WIDTH-1:0]   move_fre,
  output logic [DEEP_WIDTH-1:0]   modulate_deep,
  output logic [FACTOR_WIDTH-1:0] factor,
  output logic                    tx_am_sel,
  output logic                    rx_am_sel,
  output logic                    tx_en,
  output logic                    dp_rst,
  output logic                    settled,
  output logic                    sweep_active,
  output logic                    sweep_done
);

  localparam int CNT_W   = $clog2((SETTLE_CYC > RST_CYC) ? SETTLE_CYC : RST_CYC) + 1;
  localparam int DWELL_W = $clog2(DWELL_CYC) + 1;
  localparam logic [CNT_W-1:0]   RST_LAST    = CNT_W'(RST_CYC - 1);
  localparam logic [CNT_W-1:0]   SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
  localparam logic [DWELL_W-1:0] DWELL_LAST  = DWELL_W'(DWELL_CYC - 1);

  typedef enum logic [1:0] {
    ST_APPLY,
    ST_SETTLE,
    ST_RUN
  } state_t;

  state_t                  state;
  logic [CNT_W-1:0]        cnt;
  logic                    pending;

  logic [PHASE_WIDTH-1:0]  sh_center;
  logic [MOVE_WIDTH-1:0]   sh_move;
  logic [DEEP_WIDTH-1:0]   sh_deep;
  logic [FACTOR_WIDTH-1:0] sh_factor;
  logic [2:0]              sh_ctrl;
  logic [PHASE_WIDTH-1:0]  sh_step;
  logic [15:0]             sh_count;

  logic [PHASE_WIDTH-1:0]  nx_center;
  logic [MOVE_WIDTH-1:0]   nx_move;
  logic [DEEP_WIDTH-1:0]   nx_deep;
  logic [FACTOR_WIDTH-1:0] nx_factor;
  logic [2:0]              nx_ctrl;
  logic [PHASE_WIDTH-1:0]  nx_step;
  logic [15:0]             nx_count;

  logic [PHASE_WIDTH-1:0]  sweep_base;
  logic [PHASE_WIDTH-1:0]  sweep_inc;
  logic [15:0]             sweep_left;
  logic [DWELL_W-1:0]      dwell_cnt;

  logic                    apply_now;

  // Shadow bank as it will be after this cycle's write, so a same-cycle commit sees the write.
  always_comb begin
    nx_center = sh_center;
    nx_move   = sh_move;
    nx_deep   = sh_deep;
    nx_factor = sh_factor;
    nx_ctrl   = sh_ctrl;
    nx_step   = sh_step;
    nx_count  = sh_count;
    if (host.wr_en) begin
      case (host.wr_addr)
        3'd0:    nx_center = host.wr_data[PHASE_WIDTH-1:0];
        3'd1:    nx_move   = host.wr_data[MOVE_WIDTH-1:0];
        3'd2:    nx_deep   = host.wr_data[DEEP_WIDTH-1:0];
        3'd3:    nx_factor = host.wr_data[FACTOR_WIDTH-1:0];
        3'd4:    nx_ctrl   = host.wr_data[2:0];
        3'd5:    nx_step   = host.wr_data[PHASE_WIDTH-1:0];
        3'd6:    nx_count  = host.wr_data[15:0];
        default: ;
      endcase
    end
  end

  assign apply_now = (state == ST_RUN) && (host.commit || pending);

  always_ff @(posedge clk_in or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sh_center     <= PHASE_WIDTH'(DEF_CENTER);
      sh_move       <= MOVE_WIDTH'(DEF_MOVE);
      sh_deep       <= DEEP_WIDTH'(DEF_DEEP);
      sh_factor     <= FACTOR_WIDTH'(DEF_FACTOR);
      sh_ctrl       <= 3'b000;
      sh_step       <= '0;
      sh_count      <= 16'd0;
      center_fre    <= PHASE_WIDTH'(DEF_CENTER);
      move_fre      <= MOVE_WIDTH'(DEF_MOVE);
      modulate_deep <= DEEP_WIDTH'(DEF_DEEP);
      factor        <= FACTOR_WIDTH'(DEF_FACTOR);
      tx_am_sel     <= 1'b0;
      rx_am_sel     <= 1'b0;
      tx_en         <= 1'b0;
      dp_rst        <= 1'b1;
      settled       <= 1'b0;
      sweep_active  <= 1'b0;
      sweep_done    <= 1'b0;
      state         <= ST_APPLY;
      cnt           <= '0;
      pending       <= 1'b0;
      sweep_base    <= '0;
      sweep_inc     <= '0;
      sweep_left    <= 16'd0;
      dwell_cnt     <= '0;
    end else begin
      sh_center  <= nx_center;
      sh_move    <= nx_move;
      sh_deep    <= nx_deep;
      sh_factor  <= nx_factor;
      sh_ctrl    <= nx_ctrl;
      sh_step    <= nx_step;
      sh_count   <= nx_count;
      sweep_done <= 1'b0;

      case (state)
        ST_APPLY: begin
          if (host.commit) pending <= 1'b1;
          if (cnt == RST_LAST) begin
            state  <= ST_SETTLE;
            cnt    <= '0;
            dp_rst <= 1'b0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        ST_SETTLE: begin
          if (host.commit) pending <= 1'b1;
          if (cnt == SETTLE_LAST) begin
            state   <= ST_RUN;
            cnt     <= '0;
            settled <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        ST_RUN: begin
          if (apply_now) begin
            // A commit always wins over the sweep: the shadow centre replaces the sweep base.
            center_fre    <= nx_center;
            move_fre      <= nx_move;
            modulate_deep <= nx_deep;
            factor        <= nx_factor;
            tx_am_sel     <= nx_ctrl[0];
            rx_am_sel     <= nx_ctrl[1];
            tx_en         <= nx_ctrl[2];
            pending       <= 1'b0;
            state         <= ST_APPLY;
            cnt           <= '0;
            dp_rst        <= 1'b1;
            settled       <= 1'b0;
            sweep_active  <= 1'b0;
          end else if (sweep_active) begin
            if (dwell_cnt == DWELL_LAST) begin
              dwell_cnt <= '0;
              if (sweep_left != 16'd0) begin
                center_fre <= center_fre + sweep_inc;
                sweep_left <= sweep_left - 16'd1;
              end else begin
                center_fre   <= sweep_base;
                sweep_active <= 1'b0;
                sweep_done   <= 1'b1;
              end
            end else begin
              dwell_cnt <= dwell_cnt + DWELL_W'(1);
            end
          end else if (host.sweep_start && (nx_count != 16'd0)) begin
            // Step size is captured so later shadow writes cannot disturb a running scan.
            sweep_base   <= center_fre;
            sweep_inc    <= nx_step;
            sweep_left   <= nx_count;
            dwell_cnt    <= '0;
            sweep_active <= 1'b1;
          end
        end

        default: begin
          state  <= ST_APPLY;
          cnt    <= '0;
          dp_rst <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_modem_cfg_ctrl.sv
// tb/tb_modem_cfg_ctrl.sv - self-checking bench for modem_cfg_ctrl with a register-level reference model
module tb_modem_cfg_ctrl;
  localparam int RST = 4;
  localparam int SET = 8;
  localparam int DW  = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  modem_cfg_ctrl_if host ();

  logic [31:0] center_fre;
  logic [19:0] move_fre;
  logic [11:0] modulate_deep;
  logic [15:0] factor;
  logic        tx_am_sel, rx_am_sel, tx_en, dp_rst, settled, sweep_active, sweep_done;

  modem_cfg_ctrl #(
    .RST_CYC    (RST),
    .SETTLE_CYC (SET),
    .DWELL_CYC  (DW)
  ) dut (
    .clk_in        (clk),
    .sys_rst_n     (rst_n),
    .host          (host),
    .center_fre    (center_fre),
    .move_fre      (move_fre),
    .modulate_deep (modulate_deep),
    .factor        (factor),
    .tx_am_sel     (tx_am_sel),
    .rx_am_sel     (rx_am_sel),
    .tx_en         (tx_en),
    .dp_rst        (dp_rst),
    .settled       (settled),
    .sweep_active  (sweep_active),
    .sweep_done    (sweep_done)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: shadow bank (s_*) and active bank (m_*).
  logic [31:0] s_center, s_step, m_center;
  logic [19:0] s_move, m_move;
  logic [11:0] s_deep, m_deep;
  logic [15:0] s_factor, s_count, m_factor;
  logic [2:0]  s_ctrl, m_ctrl;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic shadow_update(input logic [2:0] a, input logic [31:0] d);
    case (a)
      3'd0: s_center = d;
      3'd1: s_move   = d[19:0];
      3'd2: s_deep   = d[11:0];
      3'd3: s_factor = d[15:0];
      3'd4: s_ctrl   = d[2:0];
      3'd5: s_step   = d;
      3'd6: s_count  = d[15:0];
      default: ;
    endcase
  endtask

  task automatic model_apply();
    m_center = s_center;
    m_move   = s_move;
    m_deep   = s_deep;
    m_factor = s_factor;
    m_ctrl   = s_ctrl;
  endtask

  task automatic do_write(input logic [2:0] a, input logic [31:0] d);
    host.wr_en   = 1'b1;
    host.wr_addr = a;
    host.wr_data = d;
    @(negedge clk);
    host.wr_en = 1'b0;
    shadow_update(a, d);
  endtask

  task automatic commit_pulse(input bit with_wr, input logic [2:0] a, input logic [31:0] d);
    host.commit  = 1'b1;
    host.wr_en   = with_wr;
    host.wr_addr = a;
    host.wr_data = d;
    @(negedge clk);
    host.commit = 1'b0;
    host.wr_en  = 1'b0;
    if (with_wr) shadow_update(a, d);
    model_apply();
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_center"}, center_fre, m_center);
    check({tag, "_move"}, 32'(move_fre), 32'(m_move));
    check({tag, "_deep"}, 32'(modulate_deep), 32'(m_deep));
    check({tag, "_factor"}, 32'(factor), 32'(m_factor));
    check({tag, "_ctrl"}, 32'({tx_en, rx_am_sel, tx_am_sel}), 32'(m_ctrl));
  endtask

  // Called on the first sample of an APPLY sequence; returns on the sample where settled rises.
  task automatic check_apply_seq(input string tag);
    logic [12:0] dp_pat, st_pat, dn_pat;
    for (int i = 0; i <= RST + SET; i++) begin
      dp_pat[i] = dp_rst;
      st_pat[i] = settled;
      dn_pat[i] = sweep_done;
      if (i < RST + SET) @(negedge clk);
    end
    check({tag, "_dprst_pat"}, 32'(dp_pat), (32'd1 << RST) - 32'd1);
    check({tag, "_settled_pat"}, 32'(st_pat), 32'd1 << (RST + SET));
    check({tag, "_done_pat"}, 32'(dn_pat), 32'd0);
  endtask

  task automatic run_sweep(input string tag, input logic [31:0] c0, input logic [31:0] step,
                           input logic [15:0] count, input int abort_t, input logic [31:0] new_c);
    logic [31:0] base, exp_c, mv;
    int n;
    do_write(3'd0, c0);
    commit_pulse(1'b0, 3'd0, 32'd0);
    check_apply_seq({tag, "_setup"});
    do_write(3'd5, step);
    do_write(3'd6, 32'(count));
    if (abort_t >= 0) do_write(3'd0, new_c);
    host.sweep_start = 1'b1;
    @(negedge clk);
    host.sweep_start = 1'b0;
    base = m_center;
    n = (int'(count) + 1) * DW;
    mv = $urandom;
    for (int t = 0; t <= n; t++) begin
      exp_c = (t < n) ? base + step * 32'(t / DW) : base;
      check({tag, "_center"}, center_fre, exp_c);
      check({tag, "_flags"}, 32'({sweep_active, sweep_done, dp_rst, settled}),
            32'({(t < n), (t == n), 1'b0, 1'b1}));
      check({tag, "_move_hold"}, 32'(move_fre), 32'(m_move));
      if (t == abort_t) begin
        commit_pulse(1'b0, 3'd0, 32'd0);
        check({tag, "_abort_active"}, 32'(sweep_active), 32'd0);
        check_outputs({tag, "_abort"});
        check_apply_seq({tag, "_abort"});
        return;
      end
      host.wr_en       = (t == 2);
      host.wr_addr     = 3'd1;
      host.wr_data     = mv;
      host.sweep_start = (t == 5);
      @(negedge clk);
      host.wr_en       = 1'b0;
      host.sweep_start = 1'b0;
      if (t == 2) shadow_update(3'd1, mv);
    end
    check({tag, "_done_once"}, 32'({sweep_done, sweep_active}), 32'd0);
    check({tag, "_restored"}, center_fre, base);
  endtask

  initial begin
    logic [31:0] c, r1, r2, r3;
    logic [2:0]  cr;
    int w;

    host.wr_en = 1'b0; host.wr_addr = 3'd0; host.wr_data = 32'd0;
    host.commit = 1'b0; host.sweep_start = 1'b0;
    s_center = 32'd459561501; s_move = 20'd262; s_deep = 12'd4090; s_factor = 16'd400;
    s_ctrl = 3'b000; s_step = 32'd0; s_count = 16'd0;
    model_apply();

    repeat (3) @(negedge clk);
    check("rst_flags", 32'({dp_rst, settled, sweep_active, sweep_done}), 32'b1000);
    check_outputs("rst");
    rst_n = 1'b1;
    check_apply_seq("reset");
    check_outputs("reset_run");

    for (int k = 0; k < 4; k++) begin
      c  = (k == 0) ? 32'd42950 : $urandom;
      cr = (k == 0) ? 3'b101 : 3'($urandom);
      do_write(3'd0, c);
      do_write(3'd4, 32'(cr));
      do_write(3'd7, $urandom);
      if (k > 0) begin
        do_write(3'd1, $urandom);
        do_write(3'd3, $urandom);
      end
      repeat (2) @(negedge clk);
      check_outputs("pre_commit");
      if (k == 0) commit_pulse(1'b0, 3'd0, 32'd0);
      else        commit_pulse(1'b1, 3'd2, $urandom);
      check_outputs("post_commit");
      check_apply_seq("commit");
    end

    r1 = $urandom; r2 = $urandom; r3 = $urandom;
    do_write(3'd0, r1);
    commit_pulse(1'b0, 3'd0, 32'd0);
    check_outputs("pend_first");
    repeat (5) @(negedge clk);
    do_write(3'd0, r2);
    host.commit = 1'b1; @(negedge clk); host.commit = 1'b0;
    do_write(3'd0, r3);
    host.commit = 1'b1; @(negedge clk); host.commit = 1'b0;
    check("pend_hold", center_fre, m_center);
    w = 0;
    while (!settled && w < 30) begin
      @(negedge clk);
      w++;
    end
    check("pend_settle_seen", 32'(settled), 32'd1);
    check("pend_wait", 32'(w), 32'd3);
    @(negedge clk);
    model_apply();
    check("pend_exec_flags", 32'({dp_rst, settled}), 32'b10);
    check_outputs("pend_exec");
    check_apply_seq("pend");
    repeat (6) @(negedge clk);
    check("pend_once", 32'({dp_rst, settled}), 32'b01);

    run_sweep("sw_dir", 32'd5000, 32'd1000, 16'd3, -1, 32'd0);
    run_sweep("sw_wrap", 32'hFFFF_FF00, 32'h200, 16'd1, -1, 32'd0);
    run_sweep("sw_rand", $urandom, $urandom, 16'($urandom_range(1, 3)), -1, 32'd0);

    do_write(3'd6, 32'd0);
    host.sweep_start = 1'b1; @(negedge clk); host.sweep_start = 1'b0;
    repeat (2) @(negedge clk);
    check("sw_zero_ignored", 32'({sweep_active, dp_rst, settled}), 32'b001);
    check_outputs("sw_zero");

    run_sweep("sw_abort", $urandom, $urandom, 16'd3, 6, $urandom);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, %0d tests run", n_tests);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/modem_cfg_ctrl.md
Name: modem_cfg_ctrl

Overview:
- Configuration sequencer for the two-way voice transceiver datapath: DDS, FM/AM modulators and demodulator.
- Holds a shadow register bank written by the host/MCU interface and transfers it atomically to the datapath on commit.
- On each commit it pulses the datapath reset, then waits a settle time before flagging the datapath valid.
- Also runs a phase-continuous carrier-frequency sweep for channel scanning.

Parameters:
- PHASE_WIDTH, 32, width of center frequency word and sweep step.
- MOVE_WIDTH, 20, width of FM deviation word.
- DEEP_WIDTH, 12, width of AM modulation depth.
- FACTOR_WIDTH, 16, width of demodulator filter factor.
- DEF_CENTER, 459561501, reset carrier word (10.7 MHz at 100 MHz).
- DEF_MOVE, 262, reset FM deviation (25 kHz).
- DEF_DEEP, 4090, reset AM depth (100%).
- DEF_FACTOR, 400, reset demodulator factor.
- RST_CYC, 4, cycles dp_rst is held after each apply.
- SETTLE_CYC, 1024, cycles waited after dp_rst before settled.
- DWELL_CYC, 65536, cycles per sweep step.

Ports:
- clk_in  in  1  system clock.
- sys_rst_n  in  1  asynchronous active-low reset.
- wr_en  in  1  shadow register write strobe.
- wr_addr  in  3  register address.
- wr_data  in  32  write data (low bits used for narrower registers).
- commit  in  1  single-cycle pulse: apply shadow bank to datapath.
- sweep_start  in  1  single-cycle pulse: start carrier sweep.
- center_fre  out  PHASE_WIDTH  active carrier word to modulators/demodulator.
- move_fre  out  MOVE_WIDTH  active FM deviation.
- modulate_deep  out  DEEP_WIDTH  active AM depth.
- factor  out  FACTOR_WIDTH  active demodulator factor.
- tx_am_sel  out  1  TX output mux: 0 = FM_wave, 1 = AM_wave.
- rx_am_sel  out  1  RX output mux: 0 = FM demod, 1 = AM demod.
- tx_en  out  1  transmitter enable.
- dp_rst  out  1  active-high datapath reset (drives RST of modulators/demodulator).
- settled  out  1  datapath configured and stable.
- sweep_active  out  1  sweep in progress.
- sweep_done  out  1  one-cycle pulse when sweep finishes.

Behaviour:
- Register map (shadow):
  - 0 CENTER = wr_data[31:0]
  - 1 MOVE = [19:0]
  - 2 DEEP = [11:0]
  - 3 FACTOR = [15:0]
  - 4 CTRL: bit0 tx_am_sel, bit1 rx_am_sel, bit2 tx_en
  - 5 SWEEP_STEP = [31:0]
  - 6 SWEEP_COUNT = [15:0]
  - 7 reserved: writes ignored.
- Shadow writes are accepted every cycle in every state; no backpressure.
- Reset (async assert, sync deassert):
  - Shadow and active registers load their DEF_* values; CTRL = 0; SWEEP_STEP = 0; SWEEP_COUNT = 0.
  - dp_rst = 1, settled = 0, sweep_active = 0, sweep_done = 0, state = APPLY, counter = 0.
  - Defaults are therefore auto-applied after reset.
- FSM states: APPLY, SETTLE, RUN.
  - APPLY: dp_rst = 1 for RST_CYC cycles, then go to SETTLE.
  - SETTLE: dp_rst = 0, counts SETTLE_CYC cycles, then go to RUN.
  - RUN: settled = 1 (registered, asserted on the first RUN cycle).
- Commit in RUN at cycle N:
  - Active registers take shadow values at edge N+1; state becomes APPLY at the same edge; settled drops at N+1.
  - settled returns after exactly RST_CYC + SETTLE_CYC cycles in APPLY/SETTLE.
- wr_en and commit in the same cycle: the write lands in shadow first and is included in the commit.
- Commit during APPLY or SETTLE: latched as pending (one deep; repeats merge). Executed on the first RUN cycle, which appears identical to a commit issued in that cycle.
- Sweep start:
  - Accepted only in RUN with no pending commit and SWEEP_COUNT != 0; otherwise ignored.
  - On accept: base register = active center_fre, sweep_active = 1, step counter = SWEEP_COUNT, dwell counter = 0.
- Sweep step:
  - Every DWELL_CYC cycles: center_fre <= center_fre + SWEEP_STEP, modulo 2^PHASE_WIDTH (wraps, no saturation).
  - Step counter decrements; no dp_rst, settled stays 1 (phase-continuous retune).
- Sweep completion:
  - After the last step and one further DWELL_CYC dwell: center_fre restored to base, sweep_active = 0, sweep_done = 1 for one cycle.
- sweep_start while sweep_active: ignored.
- Commit while sweep_active:
  - Aborts the sweep: sweep_active = 0, no sweep_done.
  - center_fre takes the shadow CENTER, not the base; normal APPLY sequence follows.
- Shadow writes during a sweep do not affect active outputs until commit.
- All outputs are registered; no combinational input-to-output paths.

Test Plan:
- Reset release (RST_CYC=4, SETTLE_CYC=8) -> dp_rst high 4 cycles, center_fre=459561501, move_fre=262, modulate_deep=4090, factor=400; settled rises exactly 12 cycles after the first post-reset edge.
- Write CENTER=32'd42950 and CTRL=3'b101, commit in RUN -> outputs unchanged before commit; next cycle center_fre=42950, tx_am_sel=1, tx_en=1, settled=0, dp_rst=1 for 4 cycles; settled back after 12.
- Commit during SETTLE, then a second commit also during SETTLE -> exactly one extra APPLY sequence starts on the RUN cycle; last shadow values applied.
- SWEEP_STEP=1000, SWEEP_COUNT=3, DWELL_CYC=4, sweep_start from center=5000 -> center_fre 5000, 6000, 7000, 8000 at 4-cycle spacing; then 5000, sweep_done single pulse, dp_rst never asserted.
- Sweep with center=32'hFFFF_FF00, step=32'h200, count=1 -> center_fre wraps to 32'h0000_0100, then restores to 32'hFFFF_FF00.
- Commit issued mid-sweep -> sweep_active falls, no sweep_done, center_fre = shadow CENTER, APPLY sequence runs.
